// File: rtl/jtpang_dma.sv
// Object-table DMA: requests the CPU bus, streams the VRAM object area into the
// object line-engine buffer through a one-stage read pipeline, then returns the bus.
module jtpang_dma #(
    parameter int AW     = 9,
    parameter int AUTOVB = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          dma_go,
    input  logic          LVBL,
    input  logic          busak_n,
    output logic          busrq_n,
    output logic [AW-1:0] dma_addr,
    input  logic [7:0]    vram_dout,
    output logic          obj_we,
    output logic [AW-1:0] obj_addr,
    output logic [7:0]    obj_din,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, REQ, COPY, REL} state_t;

    localparam logic          AUTO_EN   = (AUTOVB != 0);
    localparam logic [AW-1:0] LAST_ADDR = '1;

    state_t        state_q, state_d;
    logic          lvbl_q;
    logic          pending_q, pending_d;
    logic          v_q, v_d;
    logic          last_q, last_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] dma_addr_q, dma_addr_d;
    logic          busrq_n_q, busrq_n_d;
    logic          busy_q, busy_d;
    logic          we_q, we_d;
    logic [AW-1:0] oaddr_q, oaddr_d;
    logic [7:0]    odin_q, odin_d;
    logic          trig;

    assign trig = dma_go | (AUTO_EN & lvbl_q & ~LVBL);

    always_comb begin
        state_d    = state_q;
        v_d        = v_q;
        last_d     = last_q;
        addr_d     = addr_q;
        dma_addr_d = dma_addr_q;
        busrq_n_d  = busrq_n_q;
        busy_d     = busy_q;
        we_d       = 1'b0;
        oaddr_d    = oaddr_q;
        odin_d     = odin_q;
        // Triggers that IDLE cannot consume this cycle are remembered (1 deep).
        pending_d  = pending_q | (trig & ~((state_q == IDLE) & cen));
        if (cen) begin
            case (state_q)
                IDLE: if (trig | pending_q) begin
                    state_d    = REQ;
                    busrq_n_d  = 1'b0;
                    busy_d     = 1'b1;
                    pending_d  = 1'b0;
                    dma_addr_d = '0;
                    v_d        = 1'b0;
                    last_d     = 1'b0;
                end
                REQ: if (!busak_n) state_d = COPY;
                COPY: begin
                    if (!busak_n) begin
                        if (v_q) begin
                            we_d    = 1'b1;
                            oaddr_d = addr_q;
                            odin_d  = vram_dout;
                        end
                        if (last_q) begin
                            v_d       = 1'b0;
                            last_d    = 1'b0;
                            busrq_n_d = 1'b1;
                            state_d   = REL;
                        end else begin
                            addr_d = dma_addr_q;
                            v_d    = 1'b1;
                            if (dma_addr_q == LAST_ADDR) last_d = 1'b1;
                            else dma_addr_d = dma_addr_q + 1'b1;
                        end
                    end else begin
                        // Bus lost: drop the in-flight byte and re-issue its address later.
                        if (v_q) dma_addr_d = addr_q;
                        v_d    = 1'b0;
                        last_d = 1'b0;
                    end
                end
                REL: if (busak_n) begin
                    state_d = IDLE;
                    busy_d  = pending_q | trig;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            lvbl_q     <= 1'b1;
            pending_q  <= 1'b0;
            v_q        <= 1'b0;
            last_q     <= 1'b0;
            addr_q     <= '0;
            dma_addr_q <= '0;
            busrq_n_q  <= 1'b1;
            busy_q     <= 1'b0;
            we_q       <= 1'b0;
            oaddr_q    <= '0;
            odin_q     <= '0;
        end else begin
            state_q    <= state_d;
            lvbl_q     <= LVBL;
            pending_q  <= pending_d;
            v_q        <= v_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
            dma_addr_q <= dma_addr_d;
            busrq_n_q  <= busrq_n_d;
            busy_q     <= busy_d;
            we_q       <= we_d;
            oaddr_q    <= oaddr_d;
            odin_q     <= odin_d;
        end
    end

    assign busrq_n  = busrq_n_q;
    assign dma_addr = dma_addr_q;
    assign obj_we   = we_q;
    assign obj_addr = oaddr_q;
    assign obj_din  = odin_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_jtpang_dma.sv
// Bench for jtpang_dma: CPU/VRAM responders, write log, and a reference copy
// model (every copy must be the full table in order with data addr^5A).
module tb_jtpang_dma;
    localparam int AW = 9;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst, cen, dma_go, LVBL, busak_n;
    logic [7:0]    vram_dout;
    logic          busrq_n, obj_we, busy;
    logic [AW-1:0] dma_addr, obj_addr;
    logic [7:0]    obj_din;

    logic          go0, bk0;
    logic          busrq_n0, obj_we0, busy0;
    logic [AW-1:0] dma_addr0, obj_addr0;
    logic [7:0]    obj_din0;

    int n_assert = 0, n_fail = 0;
    int cen_mode = 0, ph = 0;
    bit force_hi = 0;
    logic cen_s = 0, bk_s = 1, rq_s = 1, rst_s = 1;
    logic [AW-1:0] addr_s;
    logic [AW+7:0] wlog[$];
    int bad_we = 0, bad_nc = 0, busy_falls = 0, rq0_low = 0;
    logic prev_busy = 0, prev_rq = 1;
    logic [AW-1:0] prev_addr = '0;

    always #5 clk = ~clk;

    jtpang_dma #(.AW(AW), .AUTOVB(1)) u_dut (
        .clk(clk), .rst(rst), .cen(cen), .dma_go(dma_go), .LVBL(LVBL),
        .busak_n(busak_n), .busrq_n(busrq_n), .dma_addr(dma_addr),
        .vram_dout(vram_dout), .obj_we(obj_we), .obj_addr(obj_addr),
        .obj_din(obj_din), .busy(busy));

    jtpang_dma #(.AW(AW), .AUTOVB(0)) u_dut0 (
        .clk(clk), .rst(rst), .cen(cen), .dma_go(go0), .LVBL(LVBL),
        .busak_n(bk0), .busrq_n(busrq_n0), .dma_addr(dma_addr0),
        .vram_dout(vram_dout), .obj_we(obj_we0), .obj_addr(obj_addr0),
        .obj_din(obj_din0), .busy(busy0));

    // CPU and VRAM responders: both react one cen after what they observe.
    initial begin
        forever begin
            @(posedge clk);
            cen_s = cen; addr_s = dma_addr; rq_s = busrq_n; bk_s = busak_n; rst_s = rst;
            #1;
            if (cen_s) begin
                vram_dout = addr_s[7:0] ^ 8'h5A;
                busak_n   = force_hi ? 1'b1 : rq_s;
            end
            case (cen_mode)
                1:       cen = (ph % 4 == 0);
                2:       cen = 1'($urandom_range(0, 1));
                default: cen = 1'b1;
            endcase
            ph++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (obj_we) begin
                wlog.push_back({obj_addr, obj_din});
                if (!cen_s || bk_s) bad_we++;
            end
            if (!rst && !rst_s && !cen_s &&
                (dma_addr !== prev_addr || busrq_n !== prev_rq || busy !== prev_busy))
                bad_nc++;
            if (prev_busy && !busy && !rst) busy_falls++;
            if (busrq_n0 !== 1'b1) rq0_low++;
            prev_busy = busy; prev_rq = busrq_n; prev_addr = dma_addr;
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach its end, failures so far %0d", n_fail);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("assertion %s", tag);
        end
    endtask

    task automatic pulse_go();
        @(posedge clk); #2 dma_go = 1'b1;
        @(posedge clk); #2 dma_go = 1'b0;
    endtask

    task automatic wait_busy(input logic val, input int maxc, input string tag);
        int n = 0;
        while (busy !== val && n < maxc) begin @(posedge clk); #1; n++; end
        chk(tag, 32'(busy), 32'(val));
    endtask

    task automatic wait_writes(input int target, input int maxc, input string tag);
        int n = 0;
        while (wlog.size() < target && n < maxc) begin @(posedge clk); #1; n++; end
        chk(tag, 32'(wlog.size() >= target), 32'd1);
    endtask

    task automatic cen_edges(input int k);
        int c = 0;
        while (c < k) begin @(posedge clk); if (cen) c++; end
    endtask

    // Reference: each copy is addresses 0..N-1 ascending, data = addr[7:0]^5A.
    task automatic check_copies(input string tag, input int ncopies);
        int mism = 0;
        chk({tag, "_count"}, 32'(wlog.size()), 32'(N * ncopies));
        foreach (wlog[i]) begin
            int a = i % N;
            logic [AW+7:0] e;
            e = {AW'(a), 8'(a & 255) ^ 8'h5A};
            if (wlog[i] !== e) mism++;
        end
        chk({tag, "_content"}, 32'(mism), 32'd0);
        wlog.delete();
    endtask

    task automatic do_gap(input int at, input int len, input string tag);
        wait_writes(at, 8000, {tag, "_reach"});
        force_hi = 1;
        cen_edges(len + 1);
        #1 chk({tag, "_rq_low"}, 32'(busrq_n), 32'd0);
        force_hi = 0;
    endtask

    initial begin
        int gap_len, gap_at, falls0;
        rst = 1; cen = 1; dma_go = 0; LVBL = 1; busak_n = 1; vram_dout = '0;
        go0 = 0; bk0 = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busrq_n", 32'(busrq_n), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_obj_we", 32'(obj_we), 32'd0);
        chk("rst_dma_addr", 32'(dma_addr), 32'd0);
        chk("rst_obj_addr", 32'(obj_addr), 32'd0);
        chk("rst_obj_din", 32'(obj_din), 32'd0);
        rst = 0;
        repeat (2) @(posedge clk);

        // Plain CPU-triggered copy
        pulse_go();
        wait_busy(1'b1, 10, "t1_busy_up");
        wait_busy(1'b0, 2000, "t1_busy_down");
        chk("t1_busrq_released", 32'(busrq_n), 32'd1);
        check_copies("t1", 1);
        $display("t1 copy done at %0t", $time);

        // VBLANK-triggered copy; the AUTOVB=0 instance must ignore it
        @(posedge clk); #2 LVBL = 1'b0;
        wait_busy(1'b1, 10, "t2_busy_up");
        wait_busy(1'b0, 2000, "t2_busy_down");
        check_copies("t2", 1);
        LVBL = 1'b1;
        repeat (5) @(posedge clk);
        chk("t2_autovb0_no_req", 32'(rq0_low), 32'd0);
        chk("t2_autovb0_busy", 32'(busy0), 32'd0);
        $display("t2 vblank copy done at %0t", $time);

        // Bus taken away after write #100
        gap_len = $urandom_range(3, 8);
        pulse_go();
        do_gap(100, gap_len, "t3_gap");
        wait_busy(1'b0, 3000, "t3_busy_down");
        check_copies("t3", 1);
        $display("t3 gap of %0d cens done at %0t", gap_len, $time);

        // Three triggers during a copy merge into one extra full copy
        falls0 = busy_falls;
        pulse_go();
        wait_writes(50, 200, "t4_reach");
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(1, 40)) @(posedge clk);
            pulse_go();
        end
        wait_busy(1'b0, 4000, "t4_busy_down");
        chk("t4_busy_single_fall", 32'(busy_falls - falls0), 32'd1);
        check_copies("t4", 2);
        $display("t4 merged retrigger done at %0t", $time);

        // No acknowledge: stuck in request until reset
        force_hi = 1;
        pulse_go();
        repeat (50) @(posedge clk);
        #1;
        chk("t5_busrq_low", 32'(busrq_n), 32'd0);
        chk("t5_busy", 32'(busy), 32'd1);
        chk("t5_no_writes", 32'(wlog.size()), 32'd0);
        chk("t5_addr_hold", 32'(dma_addr), 32'd0);
        rst = 1;
        #1;
        chk("t5_rst_busrq_n", 32'(busrq_n), 32'd1);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 0; force_hi = 0;
        repeat (4) @(posedge clk);
        $display("t5 stuck request reset at %0t", $time);

        // Quarter-rate cen
        cen_mode = 1;
        pulse_go();
        wait_busy(1'b1, 20, "t6_busy_up");
        wait_busy(1'b0, 4000, "t6_busy_down");
        check_copies("t6", 1);
        $display("t6 quarter-rate copy done at %0t", $time);

        // Random cen with a random bus gap
        cen_mode = 2;
        gap_at  = $urandom_range(20, 500);
        gap_len = $urandom_range(2, 9);
        pulse_go();
        do_gap(gap_at, gap_len, "t7_gap");
        wait_busy(1'b0, 6000, "t7_busy_down");
        check_copies("t7", 1);
        $display("t7 random-cen copy gap at %0d len %0d done at %0t", gap_at, gap_len, $time);

        chk("all_we_qualified", 32'(bad_we), 32'd0);
        chk("all_no_change_without_cen", 32'(bad_nc), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
